// File: rtl/sobel_linebuffer.sv
// rtl/sobel_linebuffer.sv - two-line circular buffer producing 3x3 column taps for Sobel
module sobel_linebuffer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic [DATA_W-1:0]             in_gray,
    input  logic [23:0]                   in_rgb,
    output logic                          shift_en,
    output logic [DATA_W-1:0]             row1_dout,
    output logic [DATA_W-1:0]             row2_dout,
    output logic [DATA_W-1:0]             row3_dout,
    output logic [23:0]                   rgb_bypass_dout,
    output logic                          win_valid,
    output logic                          frame_done,
    output logic [$clog2(IMG_WIDTH)-1:0]  col_cnt,
    output logic [$clog2(IMG_HEIGHT)-1:0] row_cnt
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [DATA_W-1:0] lb0_q [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_q [IMG_WIDTH];

    logic [CW-1:0]     wcol_q, wcol_d, pos_col;
    logic [RW-1:0]     wrow_q, wrow_d, pos_row;
    logic [DATA_W-1:0] rd0, rd1;

    logic              shift_en_q, win_valid_q, frame_done_q;
    logic [DATA_W-1:0] row1_q, row2_q, row3_q;
    logic [23:0]       rgb_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;

    // Start-of-frame relocates the current pixel to (0,0) before addressing the RAMs.
    always_comb begin
        pos_col = wcol_q;
        pos_row = wrow_q;
        if (in_sof) begin
            pos_col = '0;
            pos_row = '0;
        end
        rd0    = lb0_q[pos_col];
        rd1    = lb1_q[pos_col];
        wcol_d = wcol_q;
        wrow_d = wrow_q;
        if (in_valid) begin
            if (pos_col == COL_LAST) begin
                wcol_d = '0;
                wrow_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                wcol_d = pos_col + 1'b1;
                wrow_d = pos_row;
            end
        end
    end

    // Reads above are combinational, so the shift below sees pre-write data.
    always_ff @(posedge clk) begin
        if (!rst && in_valid) begin
            lb1_q[pos_col] <= rd0;
            lb0_q[pos_col] <= in_gray;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcol_q       <= '0;
            wrow_q       <= '0;
            shift_en_q   <= 1'b0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            row1_q       <= '0;
            row2_q       <= '0;
            row3_q       <= '0;
            rgb_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
        end else begin
            wcol_q     <= wcol_d;
            wrow_q     <= wrow_d;
            shift_en_q <= in_valid;
            if (in_valid) begin
                row3_q       <= in_gray;
                row2_q       <= (pos_row == '0) ? '0 : rd0;
                row1_q       <= (pos_row < RW'(2)) ? '0 : rd1;
                rgb_q        <= in_rgb;
                col_q        <= pos_col;
                row_q        <= pos_row;
                win_valid_q  <= (pos_row >= RW'(2)) && (pos_col >= CW'(2));
                frame_done_q <= (pos_row == ROW_LAST) && (pos_col == COL_LAST);
            end else begin
                win_valid_q  <= 1'b0;
                frame_done_q <= 1'b0;
            end
        end
    end

    assign shift_en        = shift_en_q;
    assign row1_dout       = row1_q;
    assign row2_dout       = row2_q;
    assign row3_dout       = row3_q;
    assign rgb_bypass_dout = rgb_q;
    assign win_valid       = win_valid_q;
    assign frame_done      = frame_done_q;
    assign col_cnt         = col_q;
    assign row_cnt         = row_q;

endmodule
